// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register carrying control bits,
//               NUM_DATA data fields and a destination-register index.
//               SKID=1 : 2-entry skid buffer, in_ready comes from a flop.
//               SKID=0 : single register, in_ready is combinational.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready, in_ctrl, in_data, in_rd  - upstream side
//               flush                                       - kill held entries
//               out_valid/out_ready, out_ctrl, out_data, out_rd - downstream
//               occupancy (0..2), stall_cnt (saturating back-pressure count)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 5,
  parameter int SKID     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]           in_rd,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]           out_rd,
  output logic [1:0]                 occupancy,
  output logic [15:0]                stall_cnt
);

  localparam int PAY_W = NUM_DATA * DATA_W;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [PAY_W-1:0]    main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [REG_W-1:0]    main_rd_q,   main_rd_d,   skid_rd_q,   skid_rd_d;
  logic [15:0]         stall_q;
  logic                accept, drain;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          main_rd_d   = in_rd;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          main_rd_d   = in_rd;
        end else if (accept) begin
          // Unreachable with SKID=0: in_ready there implies out_ready.
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          skid_rd_d   = in_rd;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d     = ONE;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          main_rd_d   = skid_rd_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush dominates any same-cycle accept; payload registers may go stale.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_rd_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

  // Back-pressure counter: keeps counting through flush, saturates at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Upstream ready
  // --------------------------------------------------------------------------
  generate
    if (SKID != 0) begin : g_skid_rdy
      logic in_ready_q;
      // Resets to 1 and is gated by rst_n so the first edge after reset
      // release can already accept, while staying low during reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != FULL);
        end
      end
      assign in_ready = in_ready_q & rst_n;
    end else begin : g_comb_rdy
      assign in_ready = rst_n & (!out_valid | out_ready);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Downstream payload
  // --------------------------------------------------------------------------
  assign out_valid = (state_q != EMPTY);
  // Bubbles must never carry write enables or branch bits.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign out_rd    = main_rd_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Instance A
//               uses default parameters (SKID=1); instance B uses SKID=0,
//               DATA_W=64, NUM_DATA=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A (defaults)
  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [4:0]  a_in_ctrl, a_out_ctrl, a_in_rd, a_out_rd;
  logic [95:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  // Instance B (SKID=0, DATA_W=64, NUM_DATA=2)
  logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [4:0]   b_in_ctrl, b_out_ctrl, b_in_rd, b_out_rd;
  logic [127:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;
  logic [15:0]  b_stall;

  pipe_stage_reg u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_ctrl   (a_in_ctrl),
    .in_data   (a_in_data),
    .in_rd     (a_in_rd),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_ctrl  (a_out_ctrl),
    .out_data  (a_out_data),
    .out_rd    (a_out_rd),
    .occupancy (a_occ),
    .stall_cnt (a_stall)
  );

  pipe_stage_reg #(
    .DATA_W   (64),
    .NUM_DATA (2),
    .SKID     (0)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_ctrl   (b_in_ctrl),
    .in_data   (b_in_data),
    .in_rd     (b_in_rd),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_ctrl  (b_out_ctrl),
    .out_data  (b_out_data),
    .out_rd    (b_out_rd),
    .occupancy (b_occ),
    .stall_cnt (b_stall)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [31:0] d, input logic [4:0] c, input logic [4:0] rd);
    a_in_valid = v;
    a_in_data  = {64'h0, d};
    a_in_ctrl  = c;
    a_in_rd    = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_ctrl = '0; b_in_rd = '0;
    b_flush = 1'b0; b_out_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    chk("rst_out_valid", 64'(a_out_valid), 64'h0);
    chk("rst_in_ready",  64'(a_in_ready),  64'h0);
    chk("rst_occ",       64'(a_occ),       64'h0);
    chk("rst_stall",     64'(a_stall),     64'h0);
    chk("rst_out_data",  64'(a_out_data[31:0]), 64'h0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'h0);
    #4 rst_n = 1'b1;

    // ---------------- streaming (A) ----------------
    a_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_drive(1'b1, 32'(i), 5'h1F, 5'(i));
      tick();
      chk("strm_valid", 64'(a_out_valid), 64'h1);
      chk("strm_data",  64'(a_out_data[31:0]), 64'(i));
      chk("strm_rd",    64'(a_out_rd), 64'(i));
      chk("strm_occ",   64'(a_occ), 64'h1);
    end
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    tick();
    chk("strm_end_valid", 64'(a_out_valid), 64'h0);
    chk("strm_end_ctrl",  64'(a_out_ctrl),  64'h0);
    chk("strm_stall",     64'(a_stall),     64'h0);

    // ---------------- back-pressure (A) ----------------
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'hAAAA0000, 5'h03, 5'd3);
    tick();
    chk("bp_occ1",   64'(a_occ), 64'h1);
    chk("bp_rdy1",   64'(a_in_ready), 64'h1);
    a_drive(1'b1, 32'hBBBB0000, 5'h05, 5'd4);
    tick();
    chk("bp_occ2",   64'(a_occ), 64'h2);
    chk("bp_rdy2",   64'(a_in_ready), 64'h0);
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    tick();
    chk("bp_hold_data", 64'(a_out_data[31:0]), 64'hAAAA0000);
    chk("bp_hold_ctrl", 64'(a_out_ctrl), 64'h03);
    chk("bp_stall",     64'(a_stall), 64'd2);
    a_out_ready = 1'b1;
    tick();
    chk("bp_B_data", 64'(a_out_data[31:0]), 64'hBBBB0000);
    chk("bp_B_rd",   64'(a_out_rd), 64'd4);
    chk("bp_occ_r",  64'(a_occ), 64'h1);
    tick();
    chk("bp_drained", 64'(a_out_valid), 64'h0);
    chk("bp_stall_final", 64'(a_stall), 64'd2);

    // ---------------- flush in FULL (A) ----------------
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h11110000, 5'h01, 5'd1);
    tick();
    a_drive(1'b1, 32'h22220000, 5'h02, 5'd2);
    tick();
    chk("fl_full", 64'(a_occ), 64'h2);
    a_flush = 1'b1;
    a_drive(1'b1, 32'hCCCC0000, 5'h1F, 5'd9);
    tick();
    a_flush = 1'b0;
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    chk("fl_valid", 64'(a_out_valid), 64'h0);
    chk("fl_ctrl",  64'(a_out_ctrl),  64'h0);
    chk("fl_occ",   64'(a_occ),       64'h0);
    chk("fl_stall", 64'(a_stall),     64'd4);
    a_out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("fl_no_C", 64'(a_out_valid), 64'h0);
    end

    // ---------------- async reset in ONE (A) ----------------
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h00001234, 5'h1F, 5'd7);
    tick();
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    chk("ar_one", 64'(a_occ), 64'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(a_out_valid), 64'h0);
    chk("ar_ctrl",  64'(a_out_ctrl),  64'h0);
    chk("ar_data",  64'(a_out_data[31:0]), 64'h0);
    chk("ar_rd",    64'(a_out_rd),    64'h0);
    chk("ar_occ",   64'(a_occ),       64'h0);
    chk("ar_stall", 64'(a_stall),     64'h0);
    chk("ar_rdy",   64'(a_in_ready),  64'h0);
    #1 rst_n = 1'b1;
    a_out_ready = 1'b1;
    a_drive(1'b1, 32'h0000E0E0, 5'h04, 5'd5);
    tick();
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    chk("ar_next_valid", 64'(a_out_valid), 64'h1);
    chk("ar_next_data",  64'(a_out_data[31:0]), 64'h0000E0E0);
    chk("ar_next_ctrl",  64'(a_out_ctrl), 64'h04);
    tick();
    chk("ar_next_drained", 64'(a_out_valid), 64'h0);

    // ---------------- SKID=0 sweep (B) ----------------
    b_out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = {64'hF0 + 64'(i), 64'(i)};
      b_in_ctrl  = 5'h1F;
      b_in_rd    = 5'(i);
      tick();
      chk("b_strm_valid", 64'(b_out_valid), 64'h1);
      chk("b_strm_f0",    b_out_data[63:0],   64'(i));
      chk("b_strm_f1",    b_out_data[127:64], 64'hF0 + 64'(i));
      chk("b_strm_occ",   64'(b_occ), 64'h1);
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    #1;
    chk("b_rdy_follow0", 64'(b_in_ready), 64'h0);
    b_out_ready = 1'b1;
    #1;
    chk("b_rdy_follow1", 64'(b_in_ready), 64'h1);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_in_data  = {64'h0, 64'h99};
    tick();
    b_in_valid = 1'b0;
    chk("b_occ_max1", 64'(b_occ), 64'h1);
    chk("b_hold",     b_out_data[63:0], 64'd5);
    b_out_ready = 1'b1;
    tick();
    chk("b_drained", 64'(b_out_valid), 64'h0);

    // ---------------- stall_cnt saturation (A) ----------------
    a_out_ready = 1'b0;
    a_drive(1'b1, 32'h0000F00D, 5'h01, 5'd1);
    tick();
    a_drive(1'b0, 32'h0, 5'h0, 5'h0);
    chk("sat_start", 64'(a_stall), 64'h0);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall", 64'(a_stall), 64'hFFFF);
    chk("sat_hold_data", 64'(a_out_data[31:0]), 64'h0000F00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
